// File: rtl/led_scroll_scheduler.sv
// Purpose: scrolls a 16-entry hex message across 8 LED digits, stepped by a
//   debounced push-button and/or a periodic auto-scroll timer.
// Latency: char is registered, one cycle after digit_sel; step_pulse one cycle after debounce completes.
module led_scroll_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_button,
  input  logic       auto_en,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [2:0] digit_sel,
  output logic [3:0] char,
  output logic [3:0] window_base,
  output logic       step_pulse
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] AT_LAST = 20'(AUTO_PERIOD - 1);

  logic        sync_d;
  logic        sync_q;
  logic [1:0]  state;
  logic [15:0] db_cnt;
  logic [19:0] at_cnt;
  logic        auto_tick;
  logic        advance;
  logic [3:0]  rd_idx;
  logic [3:0]  mem [16];

  // Two-flop synchronizer: the raw button is never looked at directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= step_button;
      sync_q <= sync_d;
    end
  end

  // Debounce FSM: a press must be stable for DEBOUNCE_CYCLES to emit one pulse,
  // and a release must be equally stable before another press is considered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state      <= HELD;
            step_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        HELD: begin
          if (!sync_q) begin
            state  <= REL_WAIT;
            db_cnt <= '0;
          end
        end
        REL_WAIT: begin
          if (sync_q) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The tick is decoded from the counter so it lands on the same edge as the wrap.
  assign auto_tick = auto_en && (at_cnt == AT_LAST);
  // A coincident press and tick still move the window by one only.
  assign advance   = step_pulse || auto_tick;
  // Digit 7 shows window_base; lower digits show later message entries.
  assign rd_idx    = window_base + 4'd7 - {1'b0, digit_sel};

  // Auto-scroll period counter; held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      at_cnt <= '0;
    end else if (at_cnt == AT_LAST) begin
      at_cnt <= '0;
    end else begin
      at_cnt <= at_cnt + 20'd1;
    end
  end

  // Window position, wrapping naturally at 16.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_base <= '0;
    end else if (advance) begin
      window_base <= window_base + 4'd1;
    end
  end

  // Message memory and registered character read; the read sees pre-edge
  // memory contents, so a same-address write shows up on the following read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 4'(i);
      end
      char <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      char <= mem[rd_idx];
    end
  end

endmodule

// File: doc/led_scroll_scheduler.md
LED_SCROLL_SCHEDULER -- requirements
Module: led_scroll_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of stable synced cycles needed to accept a press or a release (range 2..65535).
REQ-002 Parameter AUTO_PERIOD, default 1024, is the number of clk cycles between auto-scroll advances (range 2..2^20).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port step_button, input, 1 bit: raw asynchronous push-button; each accepted press advances the scroll by one.
REQ-006 Port auto_en, input, 1 bit: enables timed auto-scroll.
REQ-007 Port wr_en, input, 1 bit: message-memory write strobe.
REQ-008 Port wr_addr, input, 4 bits: message-memory write address.
REQ-009 Port wr_data, input, 4 bits: hex character to write.
REQ-010 Port digit_sel, input, 3 bits: digit currently refreshed by the LED driver (7 = an7, leftmost).
REQ-011 Port char, output, 4 bits: character code for digit_sel, registered.
REQ-012 Port window_base, output, 4 bits: message index shown on digit 7.
REQ-013 Port step_pulse, output, 1 bit: one-cycle strobe when a debounced press is accepted.

Function
REQ-014 Message memory: 16 x 4 bits; wr_en=1 writes mem[wr_addr] <= wr_data at the clock edge.
REQ-015 step_button passes through a 2-flop synchronizer (sync_q) before any use; raw input is never sampled directly.
REQ-016 Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT; 16-bit counter db_cnt.
REQ-017 IDLE: sync_q=1 -> PRESS_WAIT with db_cnt=0; otherwise stay.
REQ-018 PRESS_WAIT: sync_q=0 -> IDLE; else db_cnt increments; when db_cnt=DEBOUNCE_CYCLES-1 -> HELD and step_pulse=1 for exactly that one cycle.
REQ-019 HELD: sync_q=0 -> REL_WAIT with db_cnt=0; holding the button emits no further pulses.
REQ-020 REL_WAIT: sync_q=1 -> HELD (no pulse); else db_cnt increments; when db_cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-021 Auto timer: 20-bit at_cnt; auto_en=1: increments, and at AUTO_PERIOD-1 wraps to 0 with auto_tick=1 for one cycle; auto_en=0: at_cnt forced to 0, no tick.
REQ-022 advance = step_pulse OR auto_tick; advance=1 -> window_base <= window_base+1 mod 16 (15 wraps to 0).
REQ-023 step_pulse and auto_tick in the same cycle advance window_base by exactly 1.
REQ-024 char <= mem[(window_base + 7 - digit_sel) mod 16], latency 1 cycle from digit_sel; uses the window_base and mem values before the current edge.
REQ-025 A write to the address currently being read: char shows the old value this cycle and the new value from the next read.
REQ-026 A write and an advance in the same cycle are both performed.

Reset
REQ-027 reset=1 at a clock edge: window_base=0, char=0, step_pulse=0, FSM=IDLE, db_cnt=0, at_cnt=0, synchronizer flops=0, mem[i]=i for i=0..15.
REQ-028 Reset has priority over wr_en, advance and all FSM transitions, including mid-debounce or mid-auto-period; no pulse is produced in the reset cycle.
REQ-029 First valid char output is in the cycle after reset deasserts.

Verification
REQ-030 After reset, sweep digit_sel 7..0 -> char = 0,1,...,7 one cycle later; window_base=0.
REQ-031 DEBOUNCE_CYCLES=16: step_button high 40 cycles with a 5-cycle glitch at start -> exactly one step_pulse, window_base=1; digit_sel=7 -> char=1.
REQ-032 Bounce: step_button high 10 cycles, low 3, high 10, then low -> no step_pulse; window_base unchanged.
REQ-033 auto_en=1, AUTO_PERIOD=8, 16 advances -> window_base wraps 15->0; a press aligned to an auto_tick -> single increment.
REQ-034 Write mem[3]=A while digit_sel selects index 3 -> old value 3 first, then A; reset asserted mid-PRESS_WAIT -> no pulse, mem and base restored to defaults.
